// File: rtl/fetch_queue.sv
// Instruction fetch: PC generator, single-outstanding ibus handshake, prefetch FIFO to decode (FETCH_BYPASS_EN: same-cycle response bypass).
// Latency: request 1 cycle after the IDLE decision; entry visible the cycle after data_ok (same cycle with bypass on an empty FIFO).
// Backpressure: out_ready low holds the head; fetch stops issuing once count + inflight reaches DEPTH.

// Generic circular buffer, synchronous flush, head presented combinationally.
// Latency: pushed word reaches the head the next cycle. Backpressure: caller must not push when full.
// Pointers wrap naturally because DEPTH is a power of two.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    flush,
  input  logic                    push_vld,
  input  logic [WIDTH-1:0]        push_dat,
  input  logic                    pop_rdy,
  output logic                    head_vld,
  output logic [WIDTH-1:0]        head_dat,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign head_vld = (count != '0);
  assign head_dat = mem[rd_ptr];
  assign do_pop   = pop_rdy && head_vld;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)   rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_vld, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_vld && !flush) begin
      mem[wr_ptr] <= push_dat;
    end
  end
endmodule

module fetch_queue #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'hbfc0_0000,
  parameter int                EV_W     = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              ireq_valid,
  output logic [ADDR_W-1:0] ireq_addr,
  input  logic              iresp_addr_ok,
  input  logic              iresp_data_ok,
  input  logic [ADDR_W-1:0] iresp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_pcplus4,
  output logic [ADDR_W-1:0] out_instr,
  output logic [EV_W-1:0]   out_evector
);
  localparam int                CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0]    DEPTH_OCC = (CNT_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);
  localparam logic [EV_W-1:0]   EV_ADEL   = EV_W'(2);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] instr;
    logic [EV_W-1:0]   ev;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_DROP_REQ, S_DROP_WAIT, S_EXC
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_pc;
  logic              enq_vld;
  entry_t            enq_dat;
  logic              fifo_head_vld;
  entry_t            fifo_head_dat;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    occupancy;
  logic              inflight;
  logic              credit_ok;
  logic              misaligned;
  logic              bypass_hit;
  entry_t            head;

  // Only REQ/WAIT transactions will land in the FIFO; drop sequences never enqueue.
  assign inflight   = (state == S_REQ) || (state == S_WAIT);
  assign occupancy  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
  assign credit_ok  = occupancy < DEPTH_OCC;
  assign misaligned = (fetch_pc[1:0] != 2'b00);
  assign ireq_addr  = req_pc;

`ifdef FETCH_BYPASS_EN
  assign bypass_hit = (state == S_WAIT) && iresp_data_ok && !redirect_valid && !fifo_head_vld;
`else
  assign bypass_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!redirect_valid && credit_ok) state_nxt = misaligned ? S_EXC : S_REQ;
      end
      S_REQ: begin
        if (redirect_valid)     state_nxt = iresp_addr_ok ? S_DROP_WAIT : S_DROP_REQ;
        else if (iresp_addr_ok) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (redirect_valid)     state_nxt = iresp_data_ok ? S_IDLE : S_DROP_WAIT;
        else if (iresp_data_ok) state_nxt = S_IDLE;
      end
      S_DROP_REQ:  if (iresp_addr_ok) state_nxt = S_DROP_WAIT;
      S_DROP_WAIT: if (iresp_data_ok) state_nxt = S_IDLE;
      S_EXC:       if (redirect_valid) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ireq_valid = 1'b0;
    enq_vld    = 1'b0;
    enq_dat    = '0;
    case (state)
      S_REQ, S_DROP_REQ: ireq_valid = 1'b1;
      S_IDLE: begin
        if (!redirect_valid && credit_ok && misaligned) begin
          enq_vld    = 1'b1;
          enq_dat.pc = fetch_pc;
          enq_dat.ev = EV_ADEL;
        end
      end
      S_WAIT: begin
        // A bypassed response already consumed by decode is not written.
        if (!redirect_valid && iresp_data_ok && !(bypass_hit && out_ready)) begin
          enq_vld       = 1'b1;
          enq_dat.pc    = req_pc;
          enq_dat.instr = iresp_data;
        end
      end
      default: ;
    endcase
  end

  // req_pc holds the issued address so a redirected request keeps its stale address.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else begin
      if (redirect_valid)                          fetch_pc <= redirect_pc;
      else if (state == S_REQ && iresp_addr_ok)    fetch_pc <= fetch_pc + PC_STEP;
      if (state == S_IDLE && !redirect_valid && credit_ok && !misaligned) req_pc <= fetch_pc;
    end
  end

  fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (redirect_valid),
    .push_vld (enq_vld),
    .push_dat (enq_dat),
    .pop_rdy  (out_ready && !redirect_valid),
    .head_vld (fifo_head_vld),
    .head_dat (fifo_head_dat),
    .count    (fifo_count)
  );

  always_comb begin
    head      = fifo_head_dat;
    out_valid = fifo_head_vld;
    if (bypass_hit) begin
      head.pc    = req_pc;
      head.instr = iresp_data;
      head.ev    = '0;
      out_valid  = 1'b1;
    end
  end

  assign out_pc      = out_valid ? head.pc           : '0;
  assign out_pcplus4 = out_valid ? head.pc + PC_STEP : '0;
  assign out_instr   = out_valid ? head.instr        : '0;
  assign out_evector = out_valid ? head.ev           : '0;
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: expected bus addresses and decode entries are queued up front
// and popped by the bus responder and the decode-side monitor.
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam int          ADDR_W   = 32;
  localparam int          EV_W     = 8;
  localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        iresp_addr_ok = 1'b0;
  logic        iresp_data_ok = 1'b0;
  logic [31:0] iresp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_pcplus4;
  logic [31:0] out_instr;
  logic [7:0]  out_evector;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [7:0]  ev;
  } exp_t;

  exp_t        exp_out[$];
  logic [31:0] exp_req[$];
  exp_t        mon_e;
  int          n_chk = 0;
  int          n_pass = 0;
  int          addr_lat = 0;
  int          data_lat = 1;
  int          n_acc = 0;
  bit          mon_on = 1'b0;
  bit          ovr_on = 1'b0;
  logic [31:0] ovr_dat = '0;
  bit          bus_busy = 1'b0;
  int          bus_wcnt = 0;
  int          bus_dcnt = 0;
  logic [31:0] bus_paddr = '0;

  fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .EV_W(EV_W)) dut (
    .clk(clk), .resetn(resetn),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pcplus4(out_pcplus4), .out_instr(out_instr), .out_evector(out_evector)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9bdf;
  endfunction

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_stream(input logic [31:0] base, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.pc    = base + 32'(4 * i);
      e.instr = instr_of(e.pc);
      e.ev    = 8'h00;
      exp_out.push_back(e);
      exp_req.push_back(e.pc);
    end
  endtask

  task automatic start_test(input bit rdy, input int alat, input int dlat);
    resetn = 1'b0;
    redirect_valid = 1'b0;
    exp_out.delete();
    exp_req.delete();
    out_ready = rdy;
    addr_lat = alat;
    data_lat = dlat;
    n_acc = 0;
    ovr_on = 1'b0;
    mon_on = 1'b1;
    tick();
    tick();
  endtask

  task automatic release_rst(input bit redir, input logic [31:0] pc);
    resetn = 1'b1;
    redirect_valid = redir;
    redirect_pc = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_out.size() != 0; i++) tick();
    chk_eq(tag, exp_out.size(), 0);
    mon_on = 1'b0;
  endtask

  // Bus responder: addr_ok after addr_lat waiting cycles, data_ok data_lat cycles after acceptance.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      iresp_addr_ok = 1'b0;
      iresp_data_ok = 1'b0;
      iresp_data    = '0;
      if (!resetn) begin
        bus_busy = 1'b0;
        bus_wcnt = 0;
      end else if (bus_busy) begin
        bus_dcnt--;
        if (bus_dcnt == 0) begin
          iresp_data_ok = 1'b1;
          iresp_data    = ovr_on ? ovr_dat : instr_of(bus_paddr);
          ovr_on        = 1'b0;
          bus_busy      = 1'b0;
        end
      end else if (ireq_valid) begin
        if (exp_req.size() > 0) begin
          if (bus_wcnt >= addr_lat) chk_eq("req addr", ireq_addr, exp_req[0]);
          else                      chk_eq("req addr hold", ireq_addr, exp_req[0]);
        end
        if (bus_wcnt >= addr_lat) begin
          iresp_addr_ok = 1'b1;
          bus_paddr     = ireq_addr;
          if (exp_req.size() > 0) void'(exp_req.pop_front());
          bus_busy = 1'b1;
          bus_dcnt = data_lat;
          bus_wcnt = 0;
          n_acc++;
        end else begin
          bus_wcnt++;
        end
      end
    end
  end

  // Decode-side monitor: every accepted head entry is matched against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (resetn && mon_on && out_valid && out_ready && !redirect_valid) begin
        if (exp_out.size() == 0) begin
          chk_eq("out extra entry pc", out_pc, 32'h0);
        end else begin
          mon_e = exp_out.pop_front();
          chk_eq("out_pc", out_pc, mon_e.pc);
          chk_eq("out_pcplus4", out_pcplus4, mon_e.pc + 32'd4);
          chk_eq("out_instr", out_instr, mon_e.instr);
          chk_eq("out_evector", out_evector, mon_e.ev);
        end
      end
    end
  end

  initial begin
    int k;
    int nv;
    exp_t e;

    // Reset state
    tick();
    chk_eq("rst ireq_valid", ireq_valid, 0);
    chk_eq("rst ireq_addr", ireq_addr, RESET_PC);
    chk_eq("rst out_valid", out_valid, 0);
    chk_eq("rst out_pc", out_pc, 0);
    chk_eq("rst out_pcplus4", out_pcplus4, 0);
    chk_eq("rst out_instr", out_instr, 0);
    chk_eq("rst out_evector", out_evector, 0);

    // Sequential streaming from RESET_PC
    start_test(1'b1, 0, 1);
    push_stream(RESET_PC, 8);
    release_rst(1'b0, '0);
    wait_drain("stream drain", 80);

    // Backpressure: exactly DEPTH entries, then fetch resumes after the first dequeue
    start_test(1'b0, 0, 1);
    push_stream(RESET_PC, 6);
    release_rst(1'b0, '0);
    for (int i = 0; i < 30; i++) tick();
    chk_eq("full accepted reqs", n_acc, DEPTH);
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      nv += int'(ireq_valid);
    end
    chk_eq("full no req", nv, 0);
    out_ready = 1'b1;
    k = 0;
    while (!ireq_valid && k < 10) begin
      tick();
      k++;
    end
    chk_eq("resume within 2", (k <= 2), 1);
    wait_drain("resume drain", 80);

    // Redirect while in WAIT; late DEADBEEF response must be dropped
    start_test(1'b1, 0, 4);
    ovr_on = 1'b1;
    ovr_dat = 32'hdead_beef;
    exp_req.push_back(RESET_PC);
    push_stream(32'h8000_0100, 3);
    release_rst(1'b0, '0);
    for (int i = 0; i < 20 && n_acc < 1; i++) tick();
    chk_eq("wait accept", n_acc, 1);
    tick();
    redirect(32'h8000_0100);
    wait_drain("wait redirect drain", 100);

    // Redirect in REQ before addr_ok; stale address held until accepted
    start_test(1'b1, 3, 1);
    exp_req.push_back(RESET_PC);
    push_stream(32'h8000_0100, 3);
    release_rst(1'b0, '0);
    for (int i = 0; i < 10 && !ireq_valid; i++) tick();
    chk_eq("req seen", ireq_valid, 1);
    redirect(32'h8000_0100);
    wait_drain("req redirect drain", 150);

    // Misaligned PC: one exception entry, no bus request, then recovery
    start_test(1'b1, 0, 1);
    e.pc = 32'h8000_0102;
    e.instr = '0;
    e.ev = 8'h02;
    exp_out.push_back(e);
    release_rst(1'b1, 32'h8000_0102);
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      nv += int'(ireq_valid);
    end
    chk_eq("exc no req", nv, 0);
    chk_eq("exc drained", exp_out.size(), 0);
    chk_eq("exc out_valid after", out_valid, 0);
    push_stream(32'h8000_0200, 2);
    redirect(32'h8000_0200);
    wait_drain("exc recover drain", 60);

    // Redirect coincident with data_ok in WAIT
    start_test(1'b1, 0, 1);
    e.pc = 32'h8000_1000;
    e.instr = instr_of(e.pc);
    e.ev = 8'h00;
    exp_out.push_back(e);
    exp_req.push_back(32'h8000_1000);
    exp_req.push_back(32'h8000_1004);
    push_stream(32'h8000_2000, 2);
    release_rst(1'b1, 32'h8000_1000);
    for (int i = 0; i < 40 && !(n_acc == 2 && iresp_data_ok); i++) tick();
    chk_eq("dataok sync", n_acc, 2);
    redirect(32'h8000_2000);
    chk_eq("dataok redirect empty", out_valid, 0);
    wait_drain("dataok redirect drain", 60);

    // Redirect coincident with a dequeue on a full FIFO
    start_test(1'b0, 0, 1);
    for (int i = 0; i < 4; i++) exp_req.push_back(RESET_PC + 32'(4 * i));
    release_rst(1'b0, '0);
    for (int i = 0; i < 30; i++) tick();
    chk_eq("full2 accepted", n_acc, DEPTH);
    chk_eq("full2 out_valid", out_valid, 1);
    push_stream(32'h8000_3000, 2);
    out_ready = 1'b1;
    redirect(32'h8000_3000);
    chk_eq("full2 flushed", out_valid, 0);
    wait_drain("full2 drain", 60);

`ifdef FETCH_BYPASS_EN
    // Bypass: response visible the same cycle and not written to the FIFO
    start_test(1'b1, 0, 1);
    ovr_on = 1'b1;
    ovr_dat = 32'h2402_0001;
    e.pc = RESET_PC;
    e.instr = 32'h2402_0001;
    e.ev = 8'h00;
    exp_out.push_back(e);
    exp_req.push_back(RESET_PC);
    release_rst(1'b0, '0);
    for (int i = 0; i < 20 && !iresp_data_ok; i++) tick();
    chk_eq("bypass out_valid", out_valid, 1);
    chk_eq("bypass out_instr", out_instr, 32'h2402_0001);
    tick();
    chk_eq("bypass not stored", out_valid, 0);
    wait_drain("bypass drain", 10);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Next-generation instruction fetch stage: a sequential PC generator with an ibus request/response handshake and a parametrised prefetch FIFO between the bus and decode.
- Decouples bus latency from decode stalls and supports redirect (flush) while a bus transaction is in flight.
- Tags a misaligned PC with an exception vector instead of issuing a bus request.
- Sits between the PC-select logic and the decode stage.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- ADDR_W, 32, address and instruction width.
- RESET_PC, 32'hbfc0_0000, fetch PC after reset.
- EV_W, 8, exception vector width; bit 1 = instruction address error (ADEL).

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- redirect_valid  in  1  flush queue and restart fetch at redirect_pc.
- redirect_pc  in  ADDR_W  new fetch PC.
- ireq_valid  out  1  bus request valid.
- ireq_addr  out  ADDR_W  bus request address.
- iresp_addr_ok  in  1  request accepted.
- iresp_data_ok  in  1  response data valid.
- iresp_data  in  ADDR_W  instruction word.
- out_valid  out  1  head entry valid to decode.
- out_ready  in  1  decode accepts; low = stall.
- out_pc  out  ADDR_W  PC of head entry.
- out_pcplus4  out  ADDR_W  out_pc + 4, modulo 2^ADDR_W.
- out_instr  out  ADDR_W  instruction of head entry; 0 for exception entries.
- out_evector  out  EV_W  exception vector of head entry.

Behaviour:
- Reset (async, resetn low):
  - fetch PC = RESET_PC, FIFO empty, state IDLE.
  - ireq_valid = 0, ireq_addr = RESET_PC, out_valid = 0.
  - out_pc, out_pcplus4, out_instr, out_evector = 0.
  - Reset mid-transaction abandons it; any data_ok arriving after reset release while in IDLE is ignored.
- At most one outstanding bus transaction. Credit rule: a request or exception entry is issued only when count + inflight < DEPTH.
- States: IDLE, REQ, WAIT, DROP_REQ, DROP_WAIT, EXC.
  - IDLE: if fetch PC[1:0] != 0 and credit is available, enqueue {pc, instr=0, evector[1]=1} and go to EXC. Else if credit is available, go to REQ (ireq_valid asserts the next cycle). Registered request, so decision-to-request latency is 1 cycle.
  - REQ: ireq_valid = 1; ireq_addr = fetch PC, held stable until addr_ok. On addr_ok, go to WAIT and advance fetch PC by 4.
  - WAIT: on data_ok, enqueue {issued pc, iresp_data, evector=0} and return to IDLE. A new request issues 1 cycle later.
  - EXC: no fetch activity until redirect.
  - DROP_REQ: keep the old request (stale address) asserted until addr_ok, then go to DROP_WAIT.
  - DROP_WAIT: discard data on data_ok, then go to IDLE.
- Redirect (highest priority): FIFO cleared and fetch PC = redirect_pc in the same edge.
  - From IDLE or EXC: go to IDLE.
  - From REQ: go to DROP_REQ without addr_ok, or DROP_WAIT if addr_ok is in the same cycle.
  - From WAIT: go to DROP_WAIT without data_ok, or IDLE if data_ok is in the same cycle (data discarded).
  - From DROP_*: remain in the drop sequence; the latest redirect_pc wins.
  - A dequeue in the same cycle as a redirect has no effect beyond the flush.
- FIFO:
  - out_* reflect the head entry; dequeue when out_valid && out_ready.
  - Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
  - Simultaneous enqueue and dequeue keeps count unchanged. When full, the credit rule guarantees no enqueue.
- out_pcplus4 is combinational from the head PC and wraps at 2^ADDR_W.

Optional Feature:
- FETCH_BYPASS_EN defined: in WAIT, if the FIFO is empty and data_ok arrives, out_* present the response combinationally in the same cycle.
  - If out_ready is also high, the entry is consumed and not written.
  - If out_ready is low, it is enqueued normally.
- FETCH_BYPASS_EN undefined: responses are always enqueued; earliest out_valid is the cycle after data_ok.

Test Plan:
- Reset release, bus returns addr_ok the same cycle and data_ok 1 cycle later, out_ready=1 → requests at bfc00000, bfc00004, ...; out_pc sequence matches, out_pcplus4 = out_pc+4, out_evector=0.
- out_ready=0 with DEPTH=4 → exactly 4 entries enqueued, then ireq_valid stays 0. Raise out_ready → fetching resumes within 2 cycles of the first dequeue.
- Redirect to 8000_0100 while in WAIT, data_ok 3 cycles later with 0xDEADBEEF → data discarded, out_valid stays 0 until the fetch of 8000_0100 completes. Same test with redirect in REQ before addr_ok → stale address held until addr_ok.
- Redirect to 8000_0102 → one entry with out_pc=8000_0102, out_instr=0, out_evector=8'h02, ireq_valid never asserts. Redirect to 8000_0200 → normal fetch resumes.
- Redirect coincident with data_ok in WAIT, and with a dequeue on a full FIFO → FIFO empty next cycle, next request address = redirect_pc.
- FETCH_BYPASS_EN: empty FIFO, out_ready=1, data_ok with 0x24020001 → out_valid=1 and out_instr=0x24020001 in the same cycle; count remains 0.
